// File: rtl/rbus_frame_sched.sv
// Frame-level round-robin scheduler for one rbus output mux: grants one requester
// per frame, watches the muxed stream for frame boundaries and flags protocol errors.
module rbus_frame_sched #(
  parameter int N       = 4,
  parameter int SW      = $clog2(N),
  parameter int TIMEOUT = 255,
  parameter int MAX_LEN = 64,
  parameter int GAP     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_cls,
  input  logic [1:0]    o_rdy,
  input  logic          i_stb,
  input  logic          i_sof,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_sel,
  output logic          o_sel_vld,
  output logic          ff_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(MAX_LEN + 2);
  localparam int GW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_ptr;
  logic [N-1:0]  r_gnt;
  logic [SW-1:0] r_sel;
  logic          r_vld;
  logic          r_err;
  logic [TW-1:0] r_tmo;
  logic [LW-1:0] r_wc;
  logic [GW-1:0] r_gap;

  logic [N-1:0]  w_elig;
  logic          w_any;
  logic [SW-1:0] w_win;
  logic [N-1:0]  w_win_oh;
  logic          w_sof;
  logic          w_req_held;
  logic          w_tmo_hit;
  logic          w_revoke;
  logic          w_err_set;

  // Per-requester eligibility: pending frame and its class is ready downstream.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < N; k++) begin
      w_elig[k] = i_req[k] && o_rdy[i_cls[k]];
    end
  end

  // Round-robin search starting just after the last granted index.
  always_comb begin
    logic [SW-1:0] v_idx;
    v_idx = '0;
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 1; i <= N; i++) begin
      v_idx = SW'((int'(r_ptr) + i) % N);
      if (!w_any && w_elig[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end else begin
        w_any = w_any;
      end
    end
  end

  assign w_win_oh   = {{(N-1){1'b0}}, 1'b1} << w_win;
  assign w_sof      = i_stb && i_sof;
  assign w_req_held = i_req[r_sel];
  assign w_tmo_hit  = (r_tmo >= TW'(TIMEOUT));

  // In WAIT, sof wins over req-drop, which wins over timeout.
  assign w_revoke = ((r_state == S_WAIT) && !w_sof && (!w_req_held || w_tmo_hit)) ||
                    ((r_state == S_XFER) && !i_stb);

  assign w_err_set = (((r_state == S_IDLE) || (r_state == S_GAP)) && i_stb) ||
                     ((r_state == S_WAIT) && i_stb && !i_sof) ||
                     ((r_state == S_WAIT) && !w_sof && w_req_held && w_tmo_hit) ||
                     ((r_state == S_XFER) && w_sof) ||
                     ((r_state == S_XFER) && i_stb && (r_wc >= LW'(MAX_LEN)));

  // Scheduler FSM: grant, wait for sof, hold through the frame, then gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= SW'(N - 1);
      r_gnt   <= '0;
      r_sel   <= '0;
      r_vld   <= 1'b0;
      r_tmo   <= '0;
      r_wc    <= '0;
      r_gap   <= '0;
    end else if (w_revoke) begin
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_tmo   <= '0;
      r_wc    <= '0;
      r_gap   <= GW'(1);
      r_state <= (GAP == 0) ? S_IDLE : S_GAP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win_oh;
            r_sel   <= w_win;
            r_vld   <= 1'b1;
            r_ptr   <= w_win;
            r_tmo   <= TW'(1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_sof) begin
            r_wc    <= LW'(1);
            r_tmo   <= '0;
            r_state <= S_XFER;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_XFER: begin
          // Stops one past MAX_LEN so the overlength condition stays visible.
          if (r_wc <= LW'(MAX_LEN)) begin
            r_wc <= r_wc + LW'(1);
          end
        end
        S_GAP: begin
          if (r_gap >= GW'(GAP)) begin
            r_gap   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: begin
          r_gnt   <= '0;
          r_vld   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky protocol error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_sel     = r_sel;
  assign o_sel_vld = r_vld;
  assign ff_err    = r_err;

endmodule

// File: tb/tb_rbus_frame_sched.sv
// Self-checking bench for rbus_frame_sched: a scoreboard queue holds the expected
// grant order, each scenario task compares grants, timing and the error flag.
module tb_rbus_frame_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_req;
  logic [3:0] i_cls;
  logic [1:0] o_rdy;
  logic       i_stb;
  logic       i_sof;
  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_sel_vld;
  logic       ff_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rbus_frame_sched #(.N(4), .TIMEOUT(8), .MAX_LEN(64), .GAP(1)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_cls(i_cls), .o_rdy(o_rdy),
    .i_stb(i_stb), .i_sof(i_sof), .o_gnt(o_gnt), .o_sel(o_sel),
    .o_sel_vld(o_sel_vld), .ff_err(ff_err)
  );

  task automatic sb_pop(output int e);
    if (exp_q.size() == 0) e = -1;
    else e = exp_q.pop_front();
  endtask

  task automatic wait_grant(output int idx, output bit ok);
    idx = -1;
    ok  = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (o_gnt !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    for (int k = 3; k >= 0; k--) if (ok && o_gnt[k] === 1'b1) idx = k;
  endtask

  task automatic send_frame(input int len);
    for (int w = 0; w < len; w++) begin
      i_stb = 1'b1;
      i_sof = (w == 0);
      @(negedge clk);
    end
    i_stb = 1'b0;
    i_sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 4'b0000; i_cls = 4'b0000; o_rdy = 2'b11;
    i_stb = 1'b0; i_sof = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 4'b0000; i_cls = 4'b0000; o_rdy = 2'b11;
    i_stb = 1'b0; i_sof = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (o_gnt !== 4'b0000 || o_sel !== 2'b00 || o_sel_vld !== 1'b0 || ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals got gnt=%b sel=%0d vld=%b err=%b want 0/0/0/0", o_gnt, o_sel, o_sel_vld, ff_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_gnt !== 4'b0000 || o_sel_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req got gnt=%b vld=%b want 0000/0", o_gnt, o_sel_vld);
    end
  endtask

  task automatic test_round_robin();
    int idx, e;
    bit ok;
    time t_prev, t_now;
    t_prev = 0;
    i_req = 4'b1111; i_cls = 4'b0000; o_rdy = 2'b11;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int f = 0; f < 5; f++) begin
      wait_grant(idx, ok);
      t_now = $time;
      sb_pop(e);
      n_checks++;
      if (!ok || idx != e || int'(o_sel) != e || o_sel_vld !== 1'b1 || !$onehot(o_gnt)) begin
        n_fail++;
        $display("FAIL rr_grant%0d got idx=%0d sel=%0d vld=%b gnt=%b want idx=%0d", f, idx, o_sel, o_sel_vld, o_gnt, e);
      end
      if (f > 0) begin
        n_checks++;
        if (t_now - t_prev != 60) begin
          n_fail++;
          $display("FAIL rr_period%0d got %0t want 60", f, t_now - t_prev);
        end
      end
      t_prev = t_now;
      send_frame(3);
      if (f == 4) i_req = 4'b0000;
      n_checks++;
      if (idx >= 0 && (o_gnt !== (4'b0001 << idx) || o_sel_vld !== 1'b1)) begin
        n_fail++;
        $display("FAIL rr_hold%0d got gnt=%b vld=%b want held grant %0d", f, o_gnt, o_sel_vld, idx);
      end
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (ff_err !== 1'b0 || o_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_clean got err=%b gnt=%b want 0/0000", ff_err, o_gnt);
    end
  endtask

  task automatic test_class_gating();
    int idx, e;
    bit ok;
    i_cls = 4'b0010; o_rdy = 2'b10; i_req = 4'b0011;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    for (int f = 0; f < 3; f++) begin
      wait_grant(idx, ok);
      sb_pop(e);
      n_checks++;
      if (!ok || idx != e || int'(o_sel) != e || !$onehot(o_gnt)) begin
        n_fail++;
        $display("FAIL cls_grant%0d got idx=%0d sel=%0d gnt=%b want idx=%0d", f, idx, o_sel, o_gnt, e);
      end
      send_frame(2);
      if (f == 1) o_rdy = 2'b11;
      if (f == 2) i_req = 4'b0000;
    end
    repeat (4) @(negedge clk);
    i_cls = 4'b0000;
  endtask

  task automatic test_timeout();
    int idx, e, n;
    bit ok;
    i_req = 4'b1100;
    exp_q.push_back(2); exp_q.push_back(3);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e || ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_grant got idx=%0d err=%b want idx=%0d err=0", idx, ff_err, e);
    end
    n = 0;
    while (o_gnt !== 4'b0000 && n < 20) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL tmo_len got %0d cycles want 8", n);
    end
    n_checks++;
    if (ff_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_err got %b want 1", ff_err);
    end
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e || int'(o_sel) != e) begin
      n_fail++;
      $display("FAIL tmo_next got idx=%0d sel=%0d want %0d", idx, o_sel, e);
    end
    send_frame(1);
    i_req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_req_withdrawn();
    int idx, e;
    bit ok;
    do_reset();
    i_req = 4'b0110;
    exp_q.push_back(1); exp_q.push_back(2);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e) begin
      n_fail++;
      $display("FAIL wd_grant got idx=%0d want %0d", idx, e);
    end
    @(negedge clk);
    i_req = 4'b0100;
    @(negedge clk);
    n_checks++;
    if (o_gnt !== 4'b0000 || o_sel_vld !== 1'b0 || ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_revoke got gnt=%b vld=%b err=%b want 0000/0/0", o_gnt, o_sel_vld, ff_err);
    end
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e || ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_next got idx=%0d err=%b want idx=%0d err=0", idx, ff_err, e);
    end
    send_frame(2);
    i_req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_protocol_errors();
    int idx, e;
    bit ok;
    do_reset();
    i_req = 4'b0001;
    exp_q.push_back(0);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e) begin
      n_fail++;
      $display("FAIL long_grant got idx=%0d want %0d", idx, e);
    end
    for (int w = 0; w < 70; w++) begin
      if (w == 64) begin
        n_checks++;
        if (ff_err !== 1'b0) begin
          n_fail++;
          $display("FAIL long_err_early got %b want 0 after 64 words", ff_err);
        end
      end
      i_stb = 1'b1;
      i_sof = (w == 0);
      @(negedge clk);
    end
    i_stb = 1'b0;
    i_sof = 1'b0;
    i_req = 4'b0000;
    n_checks++;
    if (o_gnt !== 4'b0001 || ff_err !== 1'b1) begin
      n_fail++;
      $display("FAIL long_hold got gnt=%b err=%b want 0001/1", o_gnt, ff_err);
    end
    @(negedge clk);
    n_checks++;
    if (o_gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL long_end got gnt=%b want 0000", o_gnt);
    end
    repeat (3) @(negedge clk);

    do_reset();
    @(negedge clk);
    i_stb = 1'b1;
    @(negedge clk);
    i_stb = 1'b0;
    n_checks++;
    if (ff_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_err got %b want 1", ff_err);
    end
    i_req = 4'b0001;
    exp_q.push_back(0);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e) begin
      n_fail++;
      $display("FAIL stray_sched got idx=%0d want %0d", idx, e);
    end
    send_frame(2);
    i_req = 4'b0000;
    repeat (5) @(negedge clk);
    n_checks++;
    if (ff_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got %b want 1", ff_err);
    end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear got %b want 0", ff_err);
    end
  endtask

  task automatic test_midframe_reset();
    int idx, e;
    bit ok;
    do_reset();
    i_req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1);
    wait_grant(idx, ok);
    sb_pop(e);
    send_frame(2);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e) begin
      n_fail++;
      $display("FAIL mr_pre got idx=%0d want %0d", idx, e);
    end
    for (int w = 0; w < 4; w++) begin
      i_stb = 1'b1;
      i_sof = (w == 0);
      @(negedge clk);
    end
    i_sof = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (o_gnt !== 4'b0000 || o_sel_vld !== 1'b0 || o_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL mr_async got gnt=%b vld=%b sel=%0d want 0000/0/0", o_gnt, o_sel_vld, o_sel);
    end
    i_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(0);
    wait_grant(idx, ok);
    sb_pop(e);
    n_checks++;
    if (!ok || idx != e || ff_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_first got idx=%0d err=%b want idx=%0d err=0", idx, ff_err, e);
    end
    send_frame(1);
    i_req = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_class_gating();
    test_timeout();
    test_req_withdrawn();
    test_protocol_errors();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
